// File: rtl/photon_arb_pkg.sv
// Shared types and defaults for the photon-count FIFO arbiter.
package photon_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

    localparam int DW_DEF    = 32;
    localparam int DROPW_DEF = 16;

    // Covers up to 8 channels, the largest supported NCH.
    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/photon_fifo_arbiter_if.sv
// Channel-side strobes/data and FIFO write-port signals of the photon arbiter.
interface photon_fifo_arbiter_if #(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int CHW = 2
);
    logic [NCH-1:0]    ch_valid;
    logic [NCH*DW-1:0] ch_data;
    logic              fifo_is_full;
    logic              wr_fifo;
    logic [DW-1:0]     dout;
    logic [CHW-1:0]    dout_ch;

    modport master (
        output ch_valid, ch_data, fifo_is_full,
        input  wr_fifo, dout, dout_ch
    );

    modport slave (
        input  ch_valid, ch_data, fifo_is_full,
        output wr_fifo, dout, dout_ch
    );
endinterface

// File: rtl/photon_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping at NCH.
module photon_rr_pick #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic           any,
    output logic [CHW-1:0] idx
);

    logic [CHW-1:0] cand;

    // Scan farthest-first so the nearest candidate after ptr wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = NCH; i >= 1; i--) begin
            cand = CHW'((int'(ptr) + i) % NCH);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/photon_fifo_arbiter.sv
// Buffers one count word per channel and shares the readout FIFO write port
// round-robin, tagging each word with its channel and tracking overrun drops.
//   state | meaning
//   IDLE  | may grant the next pending channel when FIFO not full
//   WRITE | wr_fifo is high this cycle; no grant allowed
module photon_fifo_arbiter
    import photon_arb_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = DW_DEF,
    parameter int CHW   = 2,
    parameter int DROPW = DROPW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clear_drops,
    photon_fifo_arbiter_if.slave bus,
    output logic [DROPW-1:0]     drop_cnt,
    output logic [NCH-1:0]       overrun
);

    arb_state_t       state_q, state_d;
    logic [NCH-1:0]   pending;
    logic [DW-1:0]    hold [NCH];
    logic [CHW-1:0]   ptr;
    logic             any;
    logic [CHW-1:0]   pick;
    logic             grant;
    logic [NCH-1:0]   gnt_vec, cap, drop;
    logic [DROPW-1:0] drop_num;
    logic [DROPW:0]   drop_sum;

    photon_rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
        .req (pending),
        .ptr (ptr),
        .any (any),
        .idx (pick)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !bus.fifo_is_full && any) begin
                    grant   = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: state_d = IDLE;
        endcase
    end

    // A channel granted this cycle frees its slot, so a coincident strobe refills it.
    always_comb begin
        gnt_vec = '0;
        if (grant) gnt_vec[pick] = 1'b1;
        cap      = {NCH{en}} & bus.ch_valid & (~pending | gnt_vec);
        drop     = {NCH{en}} & bus.ch_valid & pending & ~gnt_vec;
        drop_num = DROPW'(count_ones(8'(drop)));
        drop_sum = {1'b0, drop_cnt} + {1'b0, drop_num};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr         <= CHW'(NCH - 1);
            pending     <= '0;
            bus.wr_fifo <= 1'b0;
            bus.dout    <= '0;
            bus.dout_ch <= '0;
            drop_cnt    <= '0;
            overrun     <= '0;
            for (int k = 0; k < NCH; k++) hold[k] <= '0;
        end else begin
            state_q     <= state_d;
            bus.wr_fifo <= grant;
            if (grant) begin
                bus.dout    <= hold[pick];
                bus.dout_ch <= pick;
                ptr         <= pick;
            end
            pending <= cap | (pending & ~gnt_vec);
            for (int k = 0; k < NCH; k++) begin
                if (cap[k]) hold[k] <= bus.ch_data[k*DW +: DW];
            end
            if (clear_drops) begin
                drop_cnt <= drop_num;
                overrun  <= drop;
            end else begin
                drop_cnt <= drop_sum[DROPW] ? '1 : drop_sum[DROPW-1:0];
                overrun  <= overrun | drop;
            end
        end
    end

endmodule

// File: tb/tb_photon_fifo_arbiter.sv
// Directed bench for photon_fifo_arbiter with hand-computed expectations.
module tb_photon_fifo_arbiter;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int CHW   = 2;
    localparam int DROPW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             clear_drops;
    logic [DROPW-1:0] drop_cnt;
    logic [NCH-1:0]   overrun;

    int n_checks = 0;
    int n_errors = 0;

    photon_fifo_arbiter_if #(.NCH(NCH), .DW(DW), .CHW(CHW)) bus ();

    photon_fifo_arbiter #(.NCH(NCH), .DW(DW), .CHW(CHW), .DROPW(DROPW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clear_drops (clear_drops),
        .bus         (bus),
        .drop_cnt    (drop_cnt),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [DW-1:0] d);
        bus.ch_data[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.ch_valid     = '0;
        bus.ch_data      = '0;
        bus.fifo_is_full = 1'b0;
        clear_drops      = 1'b0;
        en               = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [3:0]  t5_v  [9] = '{4'b1001, 4'b0001, 4'b0000, 4'b1000, 4'b0000,
                               4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0] t5_d0 [9] = '{32'h100, 32'h101, 0, 0, 0, 32'h102, 0, 0, 0};
    logic [31:0] t5_d3 [9] = '{32'h300, 0, 0, 32'h301, 0, 0, 0, 0, 0};
    logic        t5_wr [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t5_do [9] = '{0, 32'h100, 0, 32'h300, 0, 32'h101, 0, 32'h301, 0};
    logic [1:0]  t5_ch [9] = '{0, 0, 0, 3, 0, 0, 0, 3, 0};

    initial begin
        // Reset values
        do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_wr", bus.wr_fifo, 0);
        check_val("rst_dout", bus.dout, 0);
        check_val("rst_ch", bus.dout_ch, 0);
        check_val("rst_drop", drop_cnt, 0);
        check_val("rst_ovr", overrun, 0);
        rst_n = 1'b1;

        // Single request on ch2
        bus.ch_valid = 4'b0100;
        set_ch(2, 32'h0000_1234);
        step();
        bus.ch_valid = '0;
        check_val("single_c1_wr", bus.wr_fifo, 0);
        step();
        check_val("single_c2_wr", bus.wr_fifo, 1);
        check_val("single_dout", bus.dout, 32'h1234);
        check_val("single_ch", bus.dout_ch, 2);
        step();
        check_val("single_c3_wr", bus.wr_fifo, 0);

        // All four together after reset
        do_reset();
        bus.ch_valid = 4'b1111;
        for (int k = 0; k < NCH; k++) set_ch(k, 32'hA0 + k);
        step();
        bus.ch_valid = '0;
        check_val("all_c1_wr", bus.wr_fifo, 0);
        for (int i = 0; i < NCH; i++) begin
            step();
            check_val("all_wr", bus.wr_fifo, 1);
            check_val("all_dout", bus.dout, 32'hA0 + i);
            check_val("all_ch", bus.dout_ch, i);
            step();
            check_val("all_gap", bus.wr_fifo, 0);
        end
        check_val("all_drop", drop_cnt, 0);

        // Overrun while FIFO full
        bus.fifo_is_full = 1'b1;
        bus.ch_valid = 4'b0010;
        set_ch(1, 32'h11);
        step();
        set_ch(1, 32'h22);
        step();
        bus.ch_valid = '0;
        check_val("full_drop", drop_cnt, 1);
        check_val("full_ovr", overrun, 4'b0010);
        check_val("full_wr0", bus.wr_fifo, 0);
        step();
        step();
        check_val("full_wr1", bus.wr_fifo, 0);
        bus.fifo_is_full = 1'b0;
        step();
        check_val("rel_wr", bus.wr_fifo, 1);
        check_val("rel_dout", bus.dout, 32'h11);
        check_val("rel_ch", bus.dout_ch, 1);
        step();
        check_val("rel_gap", bus.wr_fifo, 0);
        step();
        check_val("rel_once", bus.wr_fifo, 0);
        clear_drops = 1'b1;
        step();
        clear_drops = 1'b0;
        check_val("clr_drop", drop_cnt, 0);
        check_val("clr_ovr", overrun, 0);

        // ch0/ch3 re-strobing after each grant
        do_reset();
        for (int c = 0; c < 9; c++) begin
            bus.ch_valid = t5_v[c];
            set_ch(0, t5_d0[c]);
            set_ch(3, t5_d3[c]);
            step();
            check_val("alt_wr", bus.wr_fifo, t5_wr[c]);
            if (t5_wr[c]) begin
                check_val("alt_dout", bus.dout, t5_do[c]);
                check_val("alt_ch", bus.dout_ch, t5_ch[c]);
            end
        end
        bus.ch_valid = '0;
        check_val("alt_drop", drop_cnt, 0);
        step();
        check_val("alt_tail_wr", bus.wr_fifo, 1);
        check_val("alt_tail_dout", bus.dout, 32'h102);

        // en=0: no capture; held data retained and granted once re-enabled
        do_reset();
        en = 1'b0;
        bus.ch_valid = 4'b0100;
        set_ch(2, 32'h77);
        step();
        bus.ch_valid = '0;
        en = 1'b1;
        step();
        step();
        check_val("en0_nocap", bus.wr_fifo, 0);
        bus.fifo_is_full = 1'b1;
        bus.ch_valid = 4'b0100;
        set_ch(2, 32'h78);
        step();
        bus.ch_valid = 4'b0100;
        en = 1'b0;
        bus.fifo_is_full = 1'b0;
        step();
        bus.ch_valid = '0;
        step();
        check_val("en0_hold_wr", bus.wr_fifo, 0);
        check_val("en0_nodrop", drop_cnt, 0);
        en = 1'b1;
        step();
        check_val("en1_wr", bus.wr_fifo, 1);
        check_val("en1_dout", bus.dout, 32'h78);

        // Drop counter saturation and clear with coincident drop
        do_reset();
        bus.fifo_is_full = 1'b1;
        bus.ch_valid = 4'b0001;
        set_ch(0, 32'h5);
        repeat (65541) step();
        bus.ch_valid = '0;
        check_val("sat_drop", drop_cnt, 16'hFFFF);
        check_val("sat_ovr", overrun, 4'b0001);
        step();
        check_val("sat_hold", drop_cnt, 16'hFFFF);
        clear_drops = 1'b1;
        bus.ch_valid = 4'b0001;
        step();
        clear_drops = 1'b0;
        bus.ch_valid = '0;
        check_val("clr_co_drop", drop_cnt, 1);
        check_val("clr_co_ovr", overrun, 4'b0001);

        // Reset asserted during a write with three channels pending
        do_reset();
        bus.ch_valid = 4'b1111;
        for (int k = 0; k < NCH; k++) set_ch(k, 32'hC0 + k);
        step();
        bus.ch_valid = '0;
        step();
        check_val("mid_wr_pre", bus.wr_fifo, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_wr", bus.wr_fifo, 0);
        check_val("mid_dout", bus.dout, 0);
        check_val("mid_ch", bus.dout_ch, 0);
        check_val("mid_drop", drop_cnt, 0);
        check_val("mid_ovr", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("post_rst_wr", bus.wr_fifo, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/photon_fifo_arbiter.md
Name: photon_fifo_arbiter

Overview:
- Shares one photon-count FIFO write port between NCH independent pulse-counter channels.
- Each channel delivers a 32-bit count with a one-cycle data_update strobe, once per 50 Hz gate window.
- The block buffers one word per channel and grants the FIFO round-robin.
- It tags each written word with its channel index and counts samples dropped by overrun.
- It sits between the per-channel pulse-counter adapters and the readout FIFO.

Parameters:
- NCH, 4, number of counter channels (2..8).
- DW, 32, count word width.
- CHW, 2, channel-index width; must be at least clog2(NCH).
- DROPW, 16, drop-counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  block enable.
- ch_valid  in  NCH  per-channel data_update strobe, one cycle wide.
- ch_data  in  NCH*DW  per-channel count; channel k occupies bits [k*DW +: DW].
- fifo_is_full  in  1  FIFO full flag.
- clear_drops  in  1  one-cycle clear for drop_cnt and overrun.
- wr_fifo  out  1  FIFO write strobe, registered.
- dout  out  DW  count word, registered.
- dout_ch  out  CHW  channel index of dout, registered.
- drop_cnt  out  DROPW  total dropped samples, saturating.
- overrun  out  NCH  sticky per-channel drop flags.

Behaviour:
- Reset (asynchronous, rst_n low):
  - wr_fifo=0, dout=0, dout_ch=0, drop_cnt=0, overrun=0.
  - All pending flags and hold registers are 0.
  - Round-robin pointer = NCH-1, so channel 0 has first priority.
  - State = IDLE.
  - Reset asserted mid-operation discards all held samples.
- Capture, per channel k, when en=1 and ch_valid[k]=1:
  - If pending[k]=0, or channel k is granted in this same cycle: hold[k]<=ch_data[k], pending[k]<=1. This is not a drop.
  - Otherwise the new sample is discarded and the older held sample is kept. drop_cnt increments, saturating at all-ones, and overrun[k]<=1.
  - If several channels overrun in the same cycle, drop_cnt adds the number of overruns, saturating.
- clear_drops=1: drop_cnt<=number of drops in this same cycle, overrun<=drop vector of this same cycle. A coincident drop is never lost.
- FSM states: IDLE, WRITE.
  - IDLE, with en=1, fifo_is_full=0 and at least one pending:
    - Pick the first pending channel searching from ptr+1 modulo NCH.
    - Then, on the same edge: wr_fifo<=1, dout<=hold[k], dout_ch<=k, pending[k]<=0, ptr<=k, state<=WRITE.
  - IDLE, otherwise: wr_fifo stays 0 and state stays IDLE.
  - WRITE: wr_fifo<=0, state<=IDLE. dout and dout_ch hold until the next grant.
- Write-strobe rules:
  - wr_fifo is high for exactly one cycle.
  - At most one write every 2 cycles.
  - fifo_is_full is sampled only in IDLE; full asserting during WRITE does not cancel the write.
- Latency: ch_valid in cycle 0 with the arbiter idle, FIFO not full and no competitor gives wr_fifo=1 in cycle 2.
- en=0:
  - No captures, no drops counted, no new grants.
  - Pending data is retained.
  - A write already in WRITE completes normally.
  - clear_drops still acts.
- Width rules:
  - dout_ch is zero-extended to CHW.
  - drop_cnt never wraps.

Decomposition:
- Shared package photon_arb_pkg holds the state encoding (IDLE=0, WRITE=1) and the defaults for DW and DROPW.
- One sub-module, photon_rr_pick: a combinational round-robin picker.
  - Inputs: req[NCH], ptr[CHW].
  - Outputs: any, idx[CHW].
- Hold registers, counters and the FSM stay in the top module.

Test Plan:
- Single request: ch_valid[2] with ch_data[2]=0x00001234 and FIFO not full -> wr_fifo high in cycle 2 only, dout=0x00001234, dout_ch=2.
- After reset, all 4 ch_valid strobe together with data 0xA0..0xA3 -> writes in order ch0,ch1,ch2,ch3 in cycles 2,4,6,8, with wr_fifo low between writes.
- fifo_is_full=1, ch1 strobes 0x11 then 0x22 -> no write, drop_cnt=1, overrun=4'b0010. Release full -> one write with dout=0x11, dout_ch=1.
- ch0 and ch3 re-strobe immediately after each grant, with a same-cycle grant+valid on ch0 -> grants alternate 0,3,0,3 and drop_cnt stays 0.
- Force 65540 drops on ch0 -> drop_cnt=0xFFFF. Pulse clear_drops together with one new drop -> drop_cnt=1, overrun[0]=1.
- Assert rst_n low while wr_fifo=1 with 3 channels pending -> all outputs 0 immediately. After release, no write occurs without new ch_valid.
